// File: rtl/eg2000_video_pkg.sv
// Shared video types and default geometry for the EG2000 video path.
package eg2000_video_pkg;

    // One buffered pixel: {active-video flag, 4-bit colour index}.
    localparam int PIX_W = 5;
    typedef logic [PIX_W-1:0] pix_t;

    // Default geometry shared by the scandoubler and its line buffer.
    localparam int CE_HALF_DEF  = 4;
    localparam int MAX_PIX_DEF  = 512;
    localparam int HS_WIDTH_DEF = 32;

    // Pack the active flag and colour index into one buffer word.
    function automatic pix_t pack_pix(input logic p, input logic [3:0] c);
        return {p, c};
    endfunction

endpackage

// File: rtl/sd_linebuf.sv
// Two-bank line buffer: simple dual-port RAM with a registered read port.
// The top-level puts the bank select in the address MSB, so one bank is
// being filled while the other (previous line) is replayed.
module sd_linebuf
    import eg2000_video_pkg::*;
#(
    parameter int MAX_PIX = MAX_PIX_DEF,
    localparam int AW     = $clog2(MAX_PIX)
) (
    input  logic        clk,
    input  logic        i_we,
    input  logic [AW:0] i_waddr,
    input  pix_t        i_wdata,
    input  logic [AW:0] i_raddr,
    output pix_t        o_rdata
);

    pix_t r_mem [2*MAX_PIX];
    pix_t r_rdata;

    // Write port plus one-clock registered read so the array maps to block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/eg2000_scandoubler.sv
// Line doubler: captures each 15.6 kHz input line into one bank of the line
// buffer and replays the previously captured line twice at double pixel rate.
// Output stays in {pixel, colour-index} form for the downstream palette.
module eg2000_scandoubler
    import eg2000_video_pkg::*;
#(
    parameter int CE_HALF  = CE_HALF_DEF,
    parameter int MAX_PIX  = MAX_PIX_DEF,
    parameter int HS_WIDTH = HS_WIDTH_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       pixel,
    input  logic [3:0] color,
    input  logic       hsync,
    input  logic       vsync,
    output logic       ce_o,
    output logic       pixel_o,
    output logic [3:0] color_o,
    output logic       hsync_o,
    output logic       vsync_o
);

    localparam int AW = $clog2(MAX_PIX);
    localparam int PW = (CE_HALF > 1) ? $clog2(CE_HALF) : 1;
    localparam logic [AW:0]   MAX_LEN = (AW+1)'(MAX_PIX);
    localparam logic [AW:0]   HS_LIM  = (AW+1)'(HS_WIDTH);
    localparam logic [PW-1:0] PH_LAST = PW'(CE_HALF - 1);

    // Input-side state
    logic          r_hs_q;
    logic          r_vs_q;
    logic          r_bank;
    logic [AW:0]   r_wr_addr;
    logic [AW:0]   r_line_len;

    // Output-side state
    logic [PW-1:0] r_phase;
    logic [AW:0]   r_out_x;
    logic          r_ce_o;
    logic          r_pixel_o;
    logic [3:0]    r_color_o;
    logic          r_hsync_o;
    logic          r_vsync_o;

    logic          w_line_start;
    logic          w_we;
    logic          w_tick;
    logic          w_in_range;
    logic          w_x_wrap;
    logic [AW:0]   w_waddr;
    logic [AW:0]   w_raddr;
    pix_t          w_rdata;

    assign w_line_start = hsync & ~r_hs_q;
    // A ce_pix on the line-start cycle is dropped; beyond MAX_PIX writes are dropped.
    assign w_we         = ~reset & ce_pix & ~w_line_start & (r_wr_addr < MAX_LEN);
    assign w_tick       = (r_phase == PH_LAST);
    assign w_in_range   = (r_out_x < r_line_len);
    // Wrap to the repeat line at the end of the stored line; an empty line pins out_x at 0.
    assign w_x_wrap     = (r_line_len == '0) || (r_out_x >= r_line_len - (AW+1)'(1));
    assign w_waddr      = {r_bank,  r_wr_addr[AW-1:0]};
    assign w_raddr      = {~r_bank, r_out_x[AW-1:0]};

    sd_linebuf #(
        .MAX_PIX (MAX_PIX)
    ) u_linebuf (
        .clk     (clock),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (pack_pix(pixel, color)),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Capture side: sync edge detect, bank swap and write address per input line.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hs_q     <= 1'b0;
            r_vs_q     <= 1'b0;
            r_bank     <= 1'b0;
            r_wr_addr  <= '0;
            r_line_len <= '0;
        end else begin
            r_hs_q <= hsync;
            r_vs_q <= vsync;
            if (w_line_start) begin
                r_line_len <= (r_wr_addr >= MAX_LEN) ? MAX_LEN : r_wr_addr;
                r_bank     <= ~r_bank;
                r_wr_addr  <= '0;
            end else if (w_we) begin
                r_wr_addr <= r_wr_addr + (AW+1)'(1);
            end
        end
    end

    // Replay timing: output pixel phase and x position, re-synced on every input line.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase <= '0;
            r_out_x <= '0;
        end else if (w_line_start) begin
            r_phase <= '0;
            r_out_x <= '0;
        end else begin
            r_phase <= w_tick ? '0 : r_phase + PW'(1);
            if (w_tick) begin
                r_out_x <= w_x_wrap ? '0 : r_out_x + (AW+1)'(1);
            end
        end
    end

    // Output register stage: pixel data, hsync and vsync all change with ce_o.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ce_o    <= 1'b0;
            r_pixel_o <= 1'b0;
            r_color_o <= 4'd0;
            r_hsync_o <= 1'b0;
            r_vsync_o <= 1'b0;
        end else begin
            r_ce_o <= w_tick;
            if (w_tick) begin
                if (w_in_range) begin
                    {r_pixel_o, r_color_o} <= w_rdata;
                end else begin
                    r_pixel_o <= 1'b0;
                    r_color_o <= 4'd0;
                end
                r_hsync_o <= (r_out_x < HS_LIM);
                if (r_out_x == '0) begin
                    r_vsync_o <= r_vs_q;
                end
            end
        end
    end

    assign ce_o    = r_ce_o;
    assign pixel_o = r_pixel_o;
    assign color_o = r_color_o;
    assign hsync_o = r_hsync_o;
    assign vsync_o = r_vsync_o;

endmodule

// File: tb/tb_eg2000_scandoubler.sv
// Randomized bench for the scandoubler. The driver keeps a model of the
// line that was captured (after the discard and truncation rules); the
// monitor expects each output window (between input line starts) to show
// that line repeated at double rate, with hsync/vsync derived from the
// position in the repeated line.
module tb_eg2000_scandoubler;
    import eg2000_video_pkg::*;

    localparam int CE_HALF  = 4;
    localparam int MAX_PIX  = 512;
    localparam int HS_WIDTH = 32;

    logic       clk = 1'b0;
    logic       reset, ce_pix, pixel, hsync, vsync;
    logic [3:0] color;
    logic       ce_o, pixel_o, hsync_o, vsync_o;
    logic [3:0] color_o;

    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model of the line buffer contents
    pix_t cur_line[$];
    pix_t prev_line[$];
    logic m_hs   = 1'b0;
    logic cur_vs = 1'b0;

    eg2000_scandoubler #(
        .CE_HALF  (CE_HALF),
        .MAX_PIX  (MAX_PIX),
        .HS_WIDTH (HS_WIDTH)
    ) dut (
        .clock   (clk),
        .reset   (reset),
        .ce_pix  (ce_pix),
        .pixel   (pixel),
        .color   (color),
        .hsync   (hsync),
        .vsync   (vsync),
        .ce_o    (ce_o),
        .pixel_o (pixel_o),
        .color_o (color_o),
        .hsync_o (hsync_o),
        .vsync_o (vsync_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Drive one clock of input and update the captured-line model.
    task automatic drive_cyc(input logic ce, input logic p, input logic [3:0] c,
                             input logic hs, input logic vs);
        ce_pix = ce; pixel = p; color = c; hsync = hs; vsync = vs;
        if (hs && !m_hs) begin
            prev_line = cur_line;
            cur_line  = {};
        end else if (ce && cur_line.size() < MAX_PIX) begin
            cur_line.push_back(pack_pix(p, c));
        end
        m_hs = hs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; ce_pix = 1'b0; pixel = 1'b0; color = 4'd0; hsync = 1'b0; vsync = 1'b0;
        cur_vs = 1'b0; m_hs = 1'b0;
        cur_line = {}; prev_line = {};
        @(posedge clk);
        @(negedge clk);
        check_val("rst_out", 32'({ce_o, pixel_o, color_o, hsync_o, vsync_o}), 32'd0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // mode 0: random pixels; 1: pixel=1, colour=x[3:0]; 2: ce_pix on the hsync edge (5, 6, random...)
    task automatic drive_line(input int n, input int mode, input int vs_at, input logic vs_val,
                              input int rst_at);
        logic       p;
        logic [3:0] c;
        for (int j = 0; j < n; j++) begin
            if (j == rst_at) begin
                do_reset(3);
                return;
            end
            if (j == vs_at) cur_vs = vs_val;
            case (mode)
                1: begin p = 1'b1; c = 4'(j); end
                2: begin p = 1'b1; c = (j == 0) ? 4'd5 : (j == 1) ? 4'd6 : 4'($urandom_range(0, 15)); end
                default: begin p = 1'($urandom_range(0, 1)); c = 4'($urandom_range(0, 15)); end
            endcase
            for (int k = 0; k < 2*CE_HALF; k++) begin
                drive_cyc((mode == 2) ? (k == 0) : (k == CE_HALF), p, c, j < 4, cur_vs);
            end
        end
    endtask

    // Monitor state
    int   cyc = 0;
    int   last_ls = 0;
    int   span_pend = 0;
    int   win_cnt = 0;
    int   win_no = 0;
    int   idx;
    bit   win_timed = 1'b0;
    bit   close_pend = 1'b0;
    pix_t win_line[$];
    pix_t next_line[$];
    pix_t exp_px;
    logic hs_prev = 1'b0, vs_d1 = 1'b0, vs_d2 = 1'b0, exp_vs = 1'b0;

    // Check every ce_o event against the model line for the current window.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            win_line = {}; next_line = {};
            win_cnt = 0; win_timed = 1'b0; close_pend = 1'b0;
            hs_prev = 1'b0; vs_d1 = 1'b0; vs_d2 = 1'b0; exp_vs = 1'b0;
        end else begin
            if (ce_o) begin
                idx    = (win_line.size() == 0) ? 0 : win_cnt % win_line.size();
                exp_px = (win_line.size() == 0) ? pix_t'(0) : win_line[idx];
                if (idx == 0) exp_vs = vs_d2;
                check_val("evt", 32'({pixel_o, color_o, hsync_o, vsync_o}),
                          32'({exp_px, idx < HS_WIDTH, exp_vs}));
                win_cnt++;
            end
            if (close_pend) begin
                if (win_timed) check_val("count", 32'(win_cnt), 32'(span_pend / CE_HALF));
                $display("line %0d: len %0d events %0d", win_no, win_line.size(), win_cnt);
                win_no++;
                win_line   = next_line;
                win_cnt    = 0;
                win_timed  = 1'b1;
                close_pend = 1'b0;
            end
            if (hsync && !hs_prev) begin
                span_pend  = cyc - last_ls;
                last_ls    = cyc;
                next_line  = prev_line;
                close_pend = 1'b1;
            end
            hs_prev = hsync;
            vs_d2   = vs_d1;
            vs_d1   = vsync;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ce_pix = 1'b0; pixel = 1'b0; color = 4'd0; hsync = 1'b0; vsync = 1'b0;
        do_reset(4);
        repeat (20) drive_cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        drive_line(400, 0, -1, 1'b0, -1);   // first capture: replayed blank
        drive_line(400, 1, -1, 1'b0, -1);   // colour ramp
        drive_line(400, 0, -1, 1'b0, -1);   // ramp shown twice, 800 ce_o
        drive_line(600, 0, -1, 1'b0, -1);   // over-long line, truncated to 512
        drive_line(300, 0, 150, 1'b1, -1);  // vsync rises mid-line
        drive_line(200, 0, 20, 1'b0, -1);   // vsync falls
        drive_line(100, 2, -1, 1'b0, -1);   // ce_pix on the hsync edge
        drive_line(120, 0, -1, 1'b0, -1);
        drive_line(300, 0, -1, 1'b0, 200);  // reset at pixel 200
        repeat (500) drive_cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        drive_line(150, 0, -1, 1'b0, -1);   // first line start after reset: blank
        drive_line(150, 0, -1, 1'b0, -1);
        drive_line(100, 0, -1, 1'b0, -1);
        drive_line(10, 0, -1, 1'b0, -1);
        repeat (10) drive_cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
